// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a valid/ready request and
// valid-only response, holds instr/pc for execution and advances on instr_ack.
module fetch_unit #(
  parameter int unsigned       DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [DWIDTH-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DWIDTH-1:0] imem_resp_data,
  output logic [DWIDTH-1:0] instr,
  output logic [DWIDTH-1:0] pc,
  output logic [DWIDTH-1:0] pc_plus_4,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              pc_sel,
  input  logic [DWIDTH-1:0] alu_result,
  output logic              trap,
  output logic [31:0]       fetch_count
);

  localparam logic PC_PLUS_4 = 1'b0;
  localparam logic PC_ALU    = 1'b1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;

  state_t            state, state_d;
  logic [DWIDTH-1:0] pc_d, instr_d, target;
  logic [31:0]       count_d;
  logic              instr_valid_d, trap_d;

  // Request is a pure decode of state, suppressed while reset is held.
  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_req_addr  = pc;
  assign pc_plus_4      = pc + DWIDTH'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      trap        <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      trap        <= trap_d;
      fetch_count <= count_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    instr_d = instr;
    count_d = fetch_count;
    target  = pc_plus_4;
    unique case (state)
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          instr_d = imem_resp_data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ack && instr_valid) begin
          // Jump targets drop bit 0; a set bit 1 is a misaligned fetch.
          target  = (pc_sel == PC_ALU) ? (alu_result & ~DWIDTH'(1)) : pc_plus_4;
          pc_d    = target;
          count_d = fetch_count + 32'd1;
          state_d = target[1] ? S_TRAP : S_REQ;
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: state_d = S_REQ;
    endcase
    instr_valid_d = (state_d == S_HOLD);
    trap_d        = (state_d == S_TRAP);
  end

endmodule
